// File: rtl/bcd_display_ctrl_pkg.sv
// Shared types, constants and datapath helpers for the two-digit BCD display controller.
// The double-dabble step and the auto-count wrap live here so both modules agree on them.
package bcd_display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam int BIN_W  = 8;
    localparam int BCD_W  = 10;
    localparam int SR_W   = BCD_W + BIN_W;
    localparam int AUTO_W = 7;

    localparam logic [BIN_W-1:0] AUTO_MAX  = 8'd99;
    localparam logic [BIN_W-1:0] AUTO_WRAP = 8'd100;
    localparam logic [3:0]       SAT_DIGIT = 4'd9;
    localparam logic [2:0]       LAST_STEP = 3'd7;

    // One double-dabble iteration: correct each BCD digit that would overflow, then shift.
    // The 2-bit hundreds field never exceeds 2, so it needs no correction.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        if (adj[11:8] >= 4'd5) begin
            adj[11:8] = adj[11:8] + 4'd3;
        end
        if (adj[15:12] >= 4'd5) begin
            adj[15:12] = adj[15:12] + 4'd3;
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [AUTO_W-1:0] auto_next(input logic [AUTO_W-1:0] cur,
                                                    input logic [3:0]        inc);
        logic [BIN_W-1:0] sum;
        sum = {1'b0, cur} + {4'b0000, inc};
        if (sum >= AUTO_WRAP) begin
            sum = sum - AUTO_WRAP;
        end
        return sum[AUTO_W-1:0];
    endfunction

    function automatic logic [AUTO_W-1:0] seed_value(input logic [BIN_W-1:0] value);
        logic [BIN_W-1:0] clamped;
        clamped = (value > AUTO_MAX) ? AUTO_MAX : value;
        return clamped[AUTO_W-1:0];
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_bin2bcd_seq.sv
// Sequential 8-bit binary to 10-bit BCD converter: load on start, eight shift steps,
// then a single DONE cycle during which bcd holds the finished result.
module bin2bcd_seq
    import bcd_display_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_t     state;
    conv_state_t     state_next;
    logic [SR_W-1:0] sr;
    logic [2:0]      cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_STEP) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Shift register keeps its value through DONE so the commit edge sees the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr  <= {{BCD_W{1'b0}}, data};
                        cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    sr  <= dabble_step(sr);
                    cnt <= cnt + 3'd1;
                end
                default: begin
                    sr  <= sr;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign bcd  = sr[SR_W-1:BIN_W];

endmodule

// File: rtl/bcd_display_ctrl.sv
// Two-digit BCD display driver: arbitrates host writes against a prescaled auto-count
// source, converts the winner with bin2bcd_seq and holds the committed digits on the pins.
module bcd_display_ctrl
    import bcd_display_ctrl_pkg::*;
#(
    parameter int TICK_W = 23
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             mode,
    input  logic [3:0]       step,
    input  logic             wr_valid,
    input  logic [BIN_W-1:0] wr_data,
    output logic             wr_ready,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic             ovf,
    output logic             busy,
    output logic             tick,
    output logic             led
);

    localparam logic [TICK_W-1:0] PRESC_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

    logic [TICK_W-1:0] presc;
    logic [AUTO_W-1:0] auto_val;
    logic              pending;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic              accept;
    logic              launch;
    logic              start;
    logic [BIN_W-1:0]  conv_data;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_ONE;
        end
    end

    assign tick = &presc;
    assign led  = presc[TICK_W-1];

    assign wr_ready  = !conv_busy;
    assign busy      = conv_busy;
    assign accept    = wr_valid && wr_ready;
    assign launch    = wr_ready && !wr_valid && pending && mode;
    assign start     = accept || launch;
    assign conv_data = accept ? wr_data : {1'b0, auto_val};

    // A host accept reseeds the counter and swallows a coincident tick. A tick that lands
    // on a launch edge re-arms pending, so the newer value gets its own conversion later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            auto_val <= '0;
            pending  <= 1'b0;
        end else if (!mode) begin
            pending  <= 1'b0;
        end else if (accept) begin
            auto_val <= seed_value(wr_data);
            pending  <= 1'b0;
        end else if (tick) begin
            auto_val <= auto_next(auto_val, step);
            pending  <= 1'b1;
        end else if (launch) begin
            pending  <= 1'b0;
        end
    end

    bin2bcd_seq u_conv (
        .clk   (CLK),
        .rst_n (RST_N),
        .start (start),
        .data  (conv_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Any non-zero hundreds digit saturates the two-digit display at 99.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tens <= '0;
            ones <= '0;
            ovf  <= 1'b0;
        end else if (conv_done) begin
            if (conv_bcd[9:8] != 2'b00) begin
                tens <= SAT_DIGIT;
                ones <= SAT_DIGIT;
                ovf  <= 1'b1;
            end else begin
                tens <= conv_bcd[7:4];
                ones <= conv_bcd[3:0];
                ovf  <= 1'b0;
            end
        end
    end

endmodule
